// File: rtl/sys_array_tile_scheduler_if.sv
// Host/fetcher/array-side signal bundle of the tile scheduler.
// master = scheduler side, slave = host + fetcher + array side.
interface sys_array_tile_scheduler_if #(
  parameter int DIM_WIDTH = 8
);
  logic                 start;
  logic [DIM_WIDTH-1:0] dim_m;
  logic [DIM_WIDTH-1:0] dim_k;
  logic [DIM_WIDTH-1:0] dim_n;
  logic                 load_req;
  logic                 load_ack;
  logic [DIM_WIDTH-1:0] tile_m0;
  logic [DIM_WIDTH-1:0] tile_n0;
  logic [DIM_WIDTH-1:0] tile_k0;
  logic [DIM_WIDTH-1:0] tile_mh;
  logic [DIM_WIDTH-1:0] tile_nw;
  logic [DIM_WIDTH-1:0] tile_kd;
  logic                 comp_start;
  logic                 acc_clear;
  logic                 comp_ready;
  logic                 wb_req;
  logic                 wb_ack;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [31:0]          perf_cycles;
  logic [15:0]          perf_tiles;

  modport master (
    input  start, dim_m, dim_k, dim_n, load_ack, comp_ready, wb_ack,
    output load_req, tile_m0, tile_n0, tile_k0, tile_mh, tile_nw, tile_kd,
           comp_start, acc_clear, wb_req, busy, done, error, perf_cycles, perf_tiles
  );

  modport slave (
    output start, dim_m, dim_k, dim_n, load_ack, comp_ready, wb_ack,
    input  load_req, tile_m0, tile_n0, tile_k0, tile_mh, tile_nw, tile_kd,
           comp_start, acc_clear, wb_req, busy, done, error, perf_cycles, perf_tiles
  );
endinterface

// File: rtl/sys_array_tile_scheduler.sv
// Splits an M x K by K x N product into array-sized tiles (M outer, N middle, K inner).
// Define SCHED_PERF_CNT_EN to get saturating busy-cycle / comp_start counters.
module sys_array_tile_scheduler #(
  parameter int DIM_WIDTH     = 8,
  parameter int ARRAY_W       = 5,
  parameter int ARRAY_L       = 5,
  parameter int ARRAY_MAX_A_L = 5,
  parameter int MAX_DIM       = 100
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sys_array_tile_scheduler_if.master bus
);
  typedef logic [DIM_WIDTH-1:0] dim_t;
  typedef logic [DIM_WIDTH:0]   xdim_t;

  localparam xdim_t CAP_M   = xdim_t'(ARRAY_W);
  localparam xdim_t CAP_N   = xdim_t'(ARRAY_L);
  localparam xdim_t CAP_K   = xdim_t'(ARRAY_MAX_A_L);
  localparam xdim_t DIM_MAX = xdim_t'(MAX_DIM);

  typedef enum logic [2:0] {IDLE, CHECK, LOAD, COMP, WAIT, WB, NEXT, DONE} state_t;

  state_t state, state_nxt;
  dim_t   dm, dk, dn;
  dim_t   m0, n0, k0, mh, nw, kd;
  logic   wait_skip, err;
  logic   load_req, comp_start, wb_req, busy, done;
  logic   dims_bad, k_last, n_wrap, m_end, ready_ok;

  // Remaining extent clipped to the array size; one extra bit keeps origin+size from wrapping.
  function automatic dim_t tile_size(input xdim_t cap, input dim_t dim, input dim_t org);
    xdim_t rem;
    rem = xdim_t'(dim) - xdim_t'(org);
    return dim_t'((rem < cap) ? rem : cap);
  endfunction

  assign dims_bad = (dm == '0) || (dk == '0) || (dn == '0) ||
                    (xdim_t'(dm) > DIM_MAX) || (xdim_t'(dk) > DIM_MAX) || (xdim_t'(dn) > DIM_MAX);
  assign k_last   = (xdim_t'(k0) + xdim_t'(kd)) >= xdim_t'(dk);
  assign n_wrap   = (xdim_t'(n0) + xdim_t'(nw)) >= xdim_t'(dn);
  assign m_end    = xdim_t'(m0) >= xdim_t'(dm);
  assign ready_ok = bus.comp_ready && !wait_skip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_req   = 1'b0;
    comp_start = 1'b0;
    wb_req     = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE) && (state != DONE);
    case (state)
      IDLE:  if (bus.start) state_nxt = CHECK;
      CHECK: state_nxt = dims_bad ? DONE : LOAD;
      LOAD: begin
        load_req = 1'b1;
        if (bus.load_ack) state_nxt = COMP;
      end
      COMP: begin
        comp_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:  if (ready_ok) state_nxt = k_last ? WB : NEXT;
      WB: begin
        wb_req = 1'b1;
        if (bus.wb_ack) state_nxt = NEXT;
      end
      NEXT:  state_nxt = m_end ? DONE : LOAD;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dm <= '0; dk <= '0; dn <= '0;
      m0 <= '0; n0 <= '0; k0 <= '0;
      mh <= '0; nw <= '0; kd <= '0;
      wait_skip <= 1'b0;
      err       <= 1'b0;
    end else begin
      wait_skip <= (state == COMP);
      case (state)
        IDLE: if (bus.start) begin
          dm  <= bus.dim_m;
          dk  <= bus.dim_k;
          dn  <= bus.dim_n;
          err <= 1'b0;
        end
        CHECK: if (dims_bad) begin
          err <= 1'b1;
        end else begin
          m0 <= '0; n0 <= '0; k0 <= '0;
          mh <= tile_size(CAP_M, dm, '0);
          nw <= tile_size(CAP_N, dn, '0);
          kd <= tile_size(CAP_K, dk, '0);
        end
        WAIT: if (ready_ok && !k_last) k0 <= dim_t'(xdim_t'(k0) + xdim_t'(kd));
        WB: if (bus.wb_ack) begin
          k0 <= '0;
          if (n_wrap) begin
            n0 <= '0;
            m0 <= dim_t'(xdim_t'(m0) + xdim_t'(mh));
          end else begin
            n0 <= dim_t'(xdim_t'(n0) + xdim_t'(nw));
          end
        end
        // Sizes follow the origins advanced on the way into NEXT.
        NEXT: if (!m_end) begin
          mh <= tile_size(CAP_M, dm, m0);
          nw <= tile_size(CAP_N, dn, n0);
          kd <= tile_size(CAP_K, dk, k0);
        end
        default: ;
      endcase
    end
  end

  assign bus.load_req   = load_req;
  assign bus.comp_start = comp_start;
  assign bus.acc_clear  = comp_start && (k0 == '0);
  assign bus.wb_req     = wb_req;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = err;
  assign bus.tile_m0    = m0;
  assign bus.tile_n0    = n0;
  assign bus.tile_k0    = k0;
  assign bus.tile_mh    = mh;
  assign bus.tile_nw    = nw;
  assign bus.tile_kd    = kd;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_tiles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
      perf_tiles  <= '0;
    end else if (state == IDLE && bus.start) begin
      perf_cycles <= '0;
      perf_tiles  <= '0;
    end else begin
      if (busy && perf_cycles != '1)      perf_cycles <= perf_cycles + 32'd1;
      if (comp_start && perf_tiles != '1) perf_tiles  <= perf_tiles + 16'd1;
    end
  end

  assign bus.perf_cycles = perf_cycles;
  assign bus.perf_tiles  = perf_tiles;
`else
  assign bus.perf_cycles = '0;
  assign bus.perf_tiles  = '0;
`endif
endmodule

// File: tb/tb_sys_array_tile_scheduler.sv
// Bench for sys_array_tile_scheduler: table of jobs, random jobs, mid-job reset.
module tb_sys_array_tile_scheduler;
  typedef struct packed { logic [7:0] m0, n0, k0, mh, nw, kd; } tile_t;
  typedef struct { int dm, dk, dn, ld, wd, rd, err, comps, wbs; } vec_t;

  logic  clk     = 1'b0;
  logic  reset_n = 1'b0;
  int    total   = 0;
  int    bad     = 0;
  tile_t exp_c[$];
  tile_t exp_w[$];

  always #5 clk = ~clk;

  sys_array_tile_scheduler_if #(.DIM_WIDTH(8)) bus ();

  sys_array_tile_scheduler #(
    .DIM_WIDTH(8), .ARRAY_W(5), .ARRAY_L(5), .ARRAY_MAX_A_L(5), .MAX_DIM(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic tile_t cur_tile();
    tile_t t;
    t = '{bus.tile_m0, bus.tile_n0, bus.tile_k0, bus.tile_mh, bus.tile_nw, bus.tile_kd};
    return t;
  endfunction

  function automatic int min5(input int a);
    return (a < 5) ? a : 5;
  endfunction

  // Reference: plain nested tile walk; a write-back follows the last K tile of each (m,n).
  task automatic build_model(input int dm, input int dk, input int dn);
    exp_c.delete();
    exp_w.delete();
    if (dm >= 1 && dm <= 100 && dk >= 1 && dk <= 100 && dn >= 1 && dn <= 100)
      for (int m = 0; m < dm; m += 5)
        for (int n = 0; n < dn; n += 5)
          for (int k = 0; k < dk; k += 5) begin
            tile_t t;
            t = '{8'(m), 8'(n), 8'(k), 8'(min5(dm - m)), 8'(min5(dn - n)), 8'(min5(dk - k))};
            exp_c.push_back(t);
            if (k + 5 >= dk) exp_w.push_back(t);
          end
  endtask

  task automatic run_job(input string tag, input vec_t v, input bit noise);
    tile_t got_c[$];
    tile_t got_w[$];
    logic  clr[$];
    tile_t held_l, held_w;
    int    cyc, done_cyc, busy_cyc, first_load, lw, ww, rc, unstable, last_ack, e, loads;
    int    want_c, want_w;
    bit    prev_l, prev_w, pend, gap_pend;
    cyc = 0; done_cyc = -1; busy_cyc = 0; first_load = -1; lw = 0; ww = 0; rc = 0;
    unstable = 0; last_ack = -1; loads = 0;
    prev_l = 1'b0; prev_w = 1'b0; pend = 1'b0; gap_pend = 1'b0;
    held_l = '0; held_w = '0;
    e = (v.rd + 1 > 2) ? v.rd + 1 : 2;
    build_model(v.dm, v.dk, v.dn);
    want_c = (v.comps < 0) ? exp_c.size() : v.comps;
    want_w = (v.wbs < 0) ? exp_w.size() : v.wbs;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dim_m = 8'(v.dm);
    bus.dim_k = 8'(v.dk);
    bus.dim_n = 8'(v.dn);
    while (done_cyc < 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      bus.dim_m = 8'($urandom_range(0, 255));
      bus.dim_k = 8'($urandom_range(0, 255));
      bus.dim_n = 8'($urandom_range(0, 255));
      if (cyc == 1) check({tag, " err_clr"}, 64'(bus.error), 64'(0));
      if (bus.busy) busy_cyc++;
      if (bus.comp_start) begin
        got_c.push_back(cur_tile());
        clr.push_back(bus.acc_clear);
        rc = 0; pend = 1'b1; gap_pend = 1'b1;
      end else if (pend) rc++;
      // comp_ready also pulses in the cycle that must be ignored
      bus.comp_ready = pend && (rc == 1 || rc >= v.rd + 1);
      bus.load_ack = 1'b0;
      if (bus.load_req) begin
        if (first_load < 0) first_load = cyc;
        if (!prev_l) begin
          held_l = cur_tile(); lw = 0;
          if (gap_pend) begin
            check({tag, " gap_load"}, 64'(rc), 64'(e + 2));
            gap_pend = 1'b0;
          end
        end else if (cur_tile() != held_l) unstable++;
        bus.load_ack = (lw >= v.ld);
        lw++;
        if (bus.load_ack) loads++;
      end
      prev_l = bus.load_req && !bus.load_ack;
      bus.wb_ack = 1'b0;
      if (bus.wb_req) begin
        if (!prev_w) begin
          held_w = cur_tile(); ww = 0;
          got_w.push_back(cur_tile());
          if (gap_pend) begin
            check({tag, " gap_wb"}, 64'(rc), 64'(e + 1));
            gap_pend = 1'b0;
          end
        end else if (cur_tile() != held_w) unstable++;
        bus.wb_ack = (ww >= v.wd);
        ww++;
        if (bus.wb_ack) last_ack = cyc;
      end
      prev_w = bus.wb_req && !bus.wb_ack;
      if (bus.done) begin
        done_cyc = cyc;
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'(0));
        check({tag, " err_at_done"}, 64'(bus.error), 64'(v.err));
`ifdef SCHED_PERF_CNT_EN
        check({tag, " perf_tiles"}, 64'(bus.perf_tiles), 64'(exp_c.size()));
        check({tag, " perf_cycles"}, 64'(bus.perf_cycles), 64'(busy_cyc));
`else
        check({tag, " perf_off"}, 64'({bus.perf_cycles, bus.perf_tiles}), 64'(0));
`endif
      end
      bus.start = noise && !bus.done && ($urandom_range(0, 3) == 0);
    end
    bus.start = 1'b0; bus.comp_ready = 1'b0; bus.load_ack = 1'b0; bus.wb_ack = 1'b0;
    if (done_cyc < 0) begin
      check({tag, " timeout"}, 64'(cyc), 64'(0));
    end else begin
      @(negedge clk);
      check({tag, " after_done"}, 64'({bus.done, bus.busy, bus.load_req, bus.comp_start, bus.wb_req}), 64'(0));
      check({tag, " err_hold"}, 64'(bus.error), 64'(v.err));
    end
    if (v.err != 0) begin
      check({tag, " err_done_lat"}, 64'(done_cyc), 64'(2));
      check({tag, " err_no_load"}, 64'(first_load), 64'(-1));
    end else begin
      check({tag, " first_load"}, 64'(first_load), 64'(2));
      check({tag, " wb_to_done"}, 64'(done_cyc - last_ack), 64'(2));
    end
    check({tag, " n_comp"}, 64'(got_c.size()), 64'(want_c));
    check({tag, " n_load"}, 64'(loads), 64'(want_c));
    check({tag, " n_wb"}, 64'(got_w.size()), 64'(want_w));
    check({tag, " stable"}, 64'(unstable), 64'(0));
    for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) begin
      check($sformatf("%s c_tile%0d", tag, i), 64'(got_c[i]), 64'(exp_c[i]));
      check($sformatf("%s clr%0d", tag, i), 64'(clr[i]), 64'(exp_c[i].k0 == 8'd0));
    end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check($sformatf("%s w_tile%0d", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
  endtask

  initial begin
    vec_t tbl[10];
    int   cnt;
    bus.start = 1'b0; bus.dim_m = '0; bus.dim_k = '0; bus.dim_n = '0;
    bus.load_ack = 1'b0; bus.comp_ready = 1'b0; bus.wb_ack = 1'b0;
    //          dm  dk  dn  ld wd rd err comps wbs
    tbl[0] = '{  4,  3,  4, 0, 0, 0, 0,  1,  1};
    tbl[1] = '{ 12,  7,  6, 0, 0, 0, 0, 12,  6};
    tbl[2] = '{  4,  0,  4, 0, 0, 0, 1,  0,  0};
    tbl[3] = '{  4,  3, 101, 0, 0, 0, 1, 0,  0};
    tbl[4] = '{  0,  3,  4, 0, 0, 0, 1,  0,  0};
    tbl[5] = '{ 12,  7,  6, 3, 5, 2, 0, 12,  6};
    tbl[6] = '{100,  1,  3, 1, 0, 1, 0, 20, 20};
    tbl[7] = '{  1,  1,  1, 0, 1, 0, 0,  1,  1};
    tbl[8] = '{  6,  6,  6, 2, 2, 3, 0,  8,  4};
    tbl[9] = '{  5,  5,  5, 0, 0, 1, 0,  1,  1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 64'({bus.load_req, bus.comp_start, bus.acc_clear, bus.wb_req,
                            bus.busy, bus.done, bus.error}), 64'(0));
    check("reset_tile", 64'(cur_tile()), 64'(0));
    check("reset_perf", 64'({bus.perf_cycles, bus.perf_tiles}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_job($sformatf("t%0d", i), tbl[i], (i % 3) == 2);

    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v.dm = $urandom_range(1, 12);
      v.dk = $urandom_range(1, 12);
      v.dn = $urandom_range(1, 12);
      if ($urandom_range(0, 4) == 0) v.dk = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(101, 255);
      v.ld = $urandom_range(0, 3);
      v.wd = $urandom_range(0, 3);
      v.rd = $urandom_range(0, 3);
      v.err = (v.dk == 0 || v.dk > 100) ? 1 : 0;
      v.comps = -1;
      v.wbs = -1;
      run_job($sformatf("r%0d", i), v, 1'b1);
    end

    // Reset while the second tile of a 12x7x6 job sits in WAIT.
    @(negedge clk);
    bus.start = 1'b1; bus.dim_m = 8'd12; bus.dim_k = 8'd7; bus.dim_n = 8'd6;
    bus.load_ack = 1'b1; bus.wb_ack = 1'b1; bus.comp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 2; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.comp_start) cnt++;
    end
    check("rst_reach", 64'(cnt), 64'(2));
    bus.comp_ready = 1'b0;
    @(negedge clk);
    check("rst_busy_pre", 64'(bus.busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check("rst_ctl", 64'({bus.load_req, bus.comp_start, bus.acc_clear, bus.wb_req,
                          bus.busy, bus.done, bus.error}), 64'(0));
    check("rst_tile", 64'(cur_tile()), 64'(0));
    check("rst_perf", 64'({bus.perf_cycles, bus.perf_tiles}), 64'(0));
    bus.load_ack = 1'b0; bus.wb_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_job("rerun", tbl[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
